sdp_ram_bypass: RTL and testbench

- Parametrised simple dual-port RAM: one write port, one read port, single clock.
- Generalises the 16x256 dual memory in width, depth, byte-lane writes and read latency.
- Concurrent read and write always both proceed. Same-address collisions resolve write-first via a bypass path.
- Used as the generic buffer/line store behind datapath blocks. Read results are qualified by rd_valid.

---
 rtl/sdp_ram_bypass.sv | 216 +++++++++++++++++++++
 tb/tb_sdp_ram_bypass.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_bypass.sv
// sdp_ram_bypass: parametrised simple dual-port RAM with one write port and
// one read port on a single clock. Writes are byte-lane masked. A read and a
// write to the same in-range address in the same cycle resolve write-first:
// the read returns the merged word that the array holds after the write.
// Read latency is 1 or 2 cycles, and reads are qualified by a one-cycle
// rd_valid pulse. Out-of-range writes are dropped. Out-of-range reads return 0.
//
// Build option: define SDP_RAM_COLL_CNT_EN to add the 16-bit saturating
// coll_cnt output. It counts in-range same-address read/write collisions.
// When the macro is undefined, the port and the counter are absent.
module sdp_ram_bypass #(
    parameter int DATA_W     = 16,
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid
`ifdef SDP_RAM_COLL_CNT_EN
    ,
    output logic [15:0]              coll_cnt
`endif
);

    localparam int BE_W = DATA_W / BYTE_W;

    // DEPTH held in ADDR_W+1 bits so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("sdp_ram_bypass: RD_LATENCY must be 1 or 2");
    end

    if ((BYTE_W < 1) || ((DATA_W % BYTE_W) != 0)) begin : g_bad_lanes
        $error("sdp_ram_bypass: DATA_W must be a non-zero multiple of BYTE_W");
    end

    if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
        $error("sdp_ram_bypass: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Per-lane merge: lanes with be set take new_w, all other lanes keep old_w.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end else begin
                res[i*BYTE_W +: BYTE_W] = old_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    // True when addr selects a physical word (addr < DEPTH).
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_C);
    endfunction

    // ------------------------------------------------------------------
    // Storage and pipeline state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic              s1_valid_q;
    logic              s1_valid_d;
    logic [DATA_W-1:0] s1_data_q;
    logic [DATA_W-1:0] s1_data_d;
    logic              rd_valid_q;
    logic              rd_valid_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    logic              wr_in_range_s;
    logic              rd_in_range_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic              coll_s;
    logic [DATA_W-1:0] mem_rd_s;
    logic [DATA_W-1:0] rd_word_s;

    // Request qualification. Reset wins over both ports, and out-of-range
    // writes never touch the array.
    always_comb begin
        wr_in_range_s = addr_in_range(wr_addr);
        rd_in_range_s = addr_in_range(rd_addr);
        wr_ok_s       = (~rst) & wr_en & wr_in_range_s;
        rd_ok_s       = (~rst) & rd_en;
        coll_s        = wr_ok_s & rd_ok_s & rd_in_range_s & (wr_addr == rd_addr);
    end

    // Array read word with the write-first bypass. Out-of-range reads yield 0,
    // so no unwritten or nonexistent location can leak X into the pipeline.
    always_comb begin
        if (rd_in_range_s) begin
            mem_rd_s = mem_q[rd_addr];
        end else begin
            mem_rd_s = '0;
        end

        if (!rd_in_range_s) begin
            rd_word_s = '0;
        end else if (coll_s) begin
            rd_word_s = lane_merge(mem_rd_s, wr_data, wr_be);
        end else begin
            rd_word_s = mem_rd_s;
        end
    end

    // Byte-masked array write. The array is deliberately never reset, so its
    // contents persist across rst.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Next-state for the read pipeline. Latency 1 loads the output register
    // straight from the array word. Latency 2 goes through the stage-1
    // register first. The data registers hold whenever no read lands.
    always_comb begin
        s1_valid_d = rd_ok_s;
        if (rd_ok_s) begin
            s1_data_d = rd_word_s;
        end else begin
            s1_data_d = s1_data_q;
        end

        if (RD_LATENCY == 2) begin
            rd_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rd_data_d = s1_data_q;
            end else begin
                rd_data_d = rd_data_q;
            end
        end else begin
            rd_valid_d = rd_ok_s;
            if (rd_ok_s) begin
                rd_data_d = rd_word_s;
            end else begin
                rd_data_d = rd_data_q;
            end
        end
    end

    // Pipeline registers. Reset clears every stage, so a read still in
    // flight is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

`ifdef SDP_RAM_COLL_CNT_EN
    logic [15:0] coll_cnt_q;
    logic [15:0] coll_cnt_d;

    // Saturating count of in-range collisions. coll_s is already false
    // during reset.
    always_comb begin
        if (coll_s && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_d = coll_cnt_q + 16'd1;
        end else begin
            coll_cnt_d = coll_cnt_q;
        end
    end

    // Collision counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_cnt_q <= 16'd0;
        end else begin
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign coll_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_sdp_ram_bypass.sv
// Testbench for sdp_ram_bypass. Two instances share one stimulus stream:
//   u_a : RD_LATENCY=1, DEPTH=256
//   u_b : RD_LATENCY=2, DEPTH=200 (addresses >= 200 are out of range)
// Expected read results are hand-computed and pushed into per-instance queues
// together with the cycle in which rd_valid must appear. A monitor process
// pops and compares on every rd_valid, and otherwise checks that rd_data holds.
module tb_sdp_ram_bypass;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data_a;
    logic        rd_valid_a;
    logic [15:0] rd_data_b;
    logic        rd_valid_b;
`ifdef SDP_RAM_COLL_CNT_EN
    logic [15:0] coll_cnt_a;
    logic [15:0] coll_cnt_b;
`endif

    exp_t        q [2][$];
    logic [15:0] hold [2];
    int          cyc     = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    logic        started = 1'b0;
    logic        rst_e;

    always #5 clk = ~clk;

    sdp_ram_bypass #(
        .DATA_W(16), .BYTE_W(8), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(1)
    ) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a)
`ifdef SDP_RAM_COLL_CNT_EN
        , .coll_cnt(coll_cnt_a)
`endif
    );

    sdp_ram_bypass #(
        .DATA_W(16), .BYTE_W(8), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(2)
    ) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b)
`ifdef SDP_RAM_COLL_CNT_EN
        , .coll_cnt(coll_cnt_b)
`endif
    );

    // Compare one instance's outputs against its queue for the current cycle.
    task automatic chk(input int k, input logic v, input logic [15:0] d);
        exp_t e;
        if (v === 1'b1) begin
            n_cmp++;
            if (q[k].size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid inst%0d cyc %0d: got rd_valid=1 data=%h, required rd_valid=0", k, cyc, d);
            end else begin
                e = q[k].pop_front();
                if ((d !== e.data) || (cyc != e.cyc)) begin
                    n_bad++;
                    $display("FAIL read_data inst%0d: got data=%h at cyc %0d, required data=%h at cyc %0d", k, d, cyc, e.data, e.cyc);
                end
                hold[k] = e.data;
            end
        end else begin
            n_cmp++;
            if (v !== 1'b0) begin
                n_bad++;
                $display("FAIL valid_known inst%0d cyc %0d: got rd_valid=%b, required 0", k, cyc, v);
            end
            while ((q[k].size() > 0) && (q[k][0].cyc <= cyc)) begin
                e = q[k].pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_valid inst%0d cyc %0d: got no rd_valid, required data=%h at cyc %0d", k, cyc, e.data, e.cyc);
            end
            n_cmp++;
            if (d !== hold[k]) begin
                n_bad++;
                $display("FAIL data_hold inst%0d cyc %0d: got rd_data=%h, required %h", k, cyc, d, hold[k]);
            end
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        hold[0] = 16'h0000;
        hold[1] = 16'h0000;
        forever begin
            @(posedge clk);
            cyc   = cyc + 1;
            rst_e = rst;
            #1;
            if (rst_e === 1'b1) begin
                started = 1'b1;
                q[0].delete();
                q[1].delete();
                hold[0] = 16'h0000;
                hold[1] = 16'h0000;
            end
            if (started) begin
                chk(0, rd_valid_a, rd_data_a);
                chk(1, rd_valid_b, rd_data_b);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected read results.
    // ea is the value expected from u_a, eb the value expected from u_b.
    task automatic drive(input logic r, input logic we, input logic [7:0] wa,
                         input logic [1:0] be, input logic [15:0] wd,
                         input logic re, input logic [7:0] ra,
                         input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        rst     = r;
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (re && !r) begin
            e.data = ea;
            e.cyc  = cyc + 1;
            q[0].push_back(e);
            e.data = eb;
            e.cyc  = cyc + 2;
            q[1].push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] wa, input logic [1:0] be, input logic [15:0] wd);
        drive(1'b0, 1'b1, wa, be, wd, 1'b0, 8'h00, 16'h0000, 16'h0000);
    endtask

    task automatic rd(input logic [7:0] ra, input logic [15:0] ea, input logic [15:0] eb);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b1, ra, ea, eb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0000);
        end
    endtask

    task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        // Reset for 2 cycles, then idle for 5 cycles.
        drive(1'b1, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0000);
        idle(5);

        // Full-word write, read on the next cycle, then rd_data holds.
        wr(8'h10, 2'b11, 16'hA5C3);
        rd(8'h10, 16'hA5C3, 16'hA5C3);
        idle(3);

        // Byte-lane partial write.
        wr(8'h05, 2'b11, 16'h1234);
        wr(8'h05, 2'b01, 16'hFFEE);
        rd(8'h05, 16'h12EE, 16'h12EE);
        idle(2);

        // Collision with write-first merge, then read back the array contents.
        wr(8'h07, 2'b11, 16'h0F0F);
        drive(1'b0, 1'b1, 8'h07, 2'b10, 16'hAB00, 1'b1, 8'h07, 16'hAB0F, 16'hAB0F);
`ifdef SDP_RAM_COLL_CNT_EN
        check_cnt("coll_cnt_a_first", coll_cnt_a, 16'd1);
        check_cnt("coll_cnt_b_first", coll_cnt_b, 16'd1);
`endif
        rd(8'h07, 16'hAB0F, 16'hAB0F);
        idle(2);

        // Preload addresses 0..3, then stream back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            wr(8'(i), 2'b11, 16'(i));
        end
        for (int i = 0; i < 4; i++) begin
            rd(8'(i), 16'(i), 16'(i));
        end
        idle(3);

        // wr_be=0 is a no-op. The read at a different address proceeds.
        drive(1'b0, 1'b1, 8'h10, 2'b00, 16'h7777, 1'b1, 8'h05, 16'h12EE, 16'h12EE);
        rd(8'h10, 16'hA5C3, 16'hA5C3);
        idle(2);

        // Second stream, with reset on the third read.
        rd(8'h00, 16'h0000, 16'h0000);
        rd(8'h01, 16'h0001, 16'h0001);
        drive(1'b1, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b1, 8'h02, 16'h0002, 16'h0002);
        idle(3);
        // Array contents persist across reset.
        rd(8'h10, 16'hA5C3, 16'hA5C3);
        idle(2);

        // Read and write in the same cycle at different addresses.
        drive(1'b0, 1'b1, 8'h20, 2'b11, 16'h4242, 1'b1, 8'h07, 16'hAB0F, 16'hAB0F);
        rd(8'h20, 16'h4242, 16'h4242);
        idle(2);

        // Out-of-range addresses for u_b (DEPTH=200).
        wr(8'd199, 2'b11, 16'h1111);
        wr(8'd210, 2'b11, 16'hBEEF);
        rd(8'd210, 16'hBEEF, 16'h0000);
        rd(8'd199, 16'h1111, 16'h1111);
        drive(1'b0, 1'b1, 8'd220, 2'b11, 16'h5555, 1'b1, 8'd220, 16'h5555, 16'h0000);
        idle(4);

`ifdef SDP_RAM_COLL_CNT_EN
        check_cnt("coll_cnt_a_final", coll_cnt_a, 16'd2);
        check_cnt("coll_cnt_b_final", coll_cnt_b, 16'd1);
`endif

        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (q[k].size() != 0) begin
                n_bad++;
                $display("FAIL queue_drained inst%0d: got %0d reads outstanding, required 0", k, q[k].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
